// File: rtl/uart_frame_parser.sv
// Pops bytes from a first-word-fall-through UART RX FIFO and parses
// [SOF][LEN][PAYLOAD x LEN][CHK] frames onto a valid/ready payload stream.
module uart_frame_parser #(
  parameter int                   DATA_BITS   = 8,
  parameter logic [DATA_BITS-1:0] SOF         = 8'hA5,
  parameter int                   MAX_LEN     = 16,
  parameter int                   TIMEOUT_CYC = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_empty,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_uart,
  output logic [DATA_BITS-1:0] pl_data,
  output logic                 pl_valid,
  input  logic                 pl_ready,
  output logic                 pl_last,
  output logic                 frame_ok,
  output logic                 frame_err,
  output logic [1:0]           err_code
);

  localparam logic [DATA_BITS-1:0] MAX_LEN_V  = DATA_BITS'(MAX_LEN);
  localparam logic [DATA_BITS-1:0] ONE        = DATA_BITS'(1);
  localparam logic [DATA_BITS-1:0] ZERO       = '0;
  localparam bit                   TIMER_EN   = (TIMEOUT_CYC > 0);
  localparam logic [31:0]          TIMER_LAST = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [DATA_BITS-1:0] cnt;
  logic [DATA_BITS-1:0] chk;
  logic [31:0]          timer;
  logic                 accept;
  logic                 pop;
  logic                 timeout;
  logic                 ok_next;
  logic                 err_next;
  logic [1:0]           code_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Payload pops are throttled by the output register; all other states drain freely.
  always_comb begin
    accept     = (state == ST_PAYLOAD) ? (~pl_valid | pl_ready) : 1'b1;
    pop        = ~rst & ~rx_empty & accept;
    timeout    = TIMER_EN && (state != ST_HUNT) && rx_empty && (timer == TIMER_LAST);
    state_next = state;
    ok_next    = 1'b0;
    err_next   = 1'b0;
    code_next  = err_code;
    case (state)
      ST_HUNT: begin
        if (pop && (rd_data == SOF)) begin
          state_next = ST_LEN;
        end
      end
      ST_LEN: begin
        if (pop) begin
          if (rd_data > MAX_LEN_V) begin
            err_next   = 1'b1;
            code_next  = ERR_LEN;
            state_next = ST_HUNT;
          end else if (rd_data == ZERO) begin
            state_next = ST_CHK;
          end else begin
            state_next = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (pop && (cnt == ONE)) begin
          state_next = ST_CHK;
        end
      end
      ST_CHK: begin
        if (pop) begin
          if (rd_data == chk) begin
            ok_next   = 1'b1;
            code_next = ERR_NONE;
          end else begin
            err_next  = 1'b1;
            code_next = ERR_CHK;
          end
          state_next = ST_HUNT;
        end
      end
      default: state_next = ST_HUNT;
    endcase
    if (timeout) begin
      err_next   = 1'b1;
      code_next  = ERR_TIMEOUT;
      state_next = ST_HUNT;
    end
  end

  assign rd_uart = pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      chk       <= '0;
      timer     <= '0;
      pl_data   <= '0;
      pl_valid  <= 1'b0;
      pl_last   <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      frame_ok  <= ok_next;
      frame_err <= err_next;
      err_code  <= code_next;

      if ((state == ST_LEN) && pop) begin
        cnt <= rd_data;
        chk <= rd_data;
      end else if ((state == ST_PAYLOAD) && pop) begin
        cnt <= cnt - ONE;
        chk <= chk ^ rd_data;
      end

      // A pending byte keeps draining even if the frame was aborted by a timeout.
      if ((state == ST_PAYLOAD) && pop) begin
        pl_data  <= rd_data;
        pl_valid <= 1'b1;
        pl_last  <= (cnt == ONE);
      end else if (pl_ready) begin
        pl_valid <= 1'b0;
        pl_last  <= 1'b0;
      end

      if ((state == ST_HUNT) || pop || timeout) begin
        timer <= '0;
      end else if (rx_empty) begin
        timer <= timer + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: models the FWFT RX FIFO and records the
// payload stream and status pulses, then checks them against hand-computed values.
module tb_uart_frame_parser;

  logic       clk;
  logic       rst;
  logic       rx_empty;
  logic [7:0] rd_data;
  logic       rd_uart;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       pl_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  int         checks = 0;
  int         failures = 0;
  int         ok_count = 0;
  int         err_count = 0;
  int         both_high = 0;
  int         cycle_cnt = 0;
  int         pop_edge = 0;
  int         err_cycle = 0;
  int         bad;
  logic       pop_next = 1'b0;
  logic       seen;
  logic [7:0] fifo_q[$];
  logic [7:0] got_data[$];
  logic       got_last[$];
  int         got_cycle[$];

  uart_frame_parser #(
    .DATA_BITS  (8),
    .SOF        (8'hA5),
    .MAX_LEN    (16),
    .TIMEOUT_CYC(50)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_empty (rx_empty),
    .rd_data  (rd_data),
    .rd_uart  (rd_uart),
    .pl_data  (pl_data),
    .pl_valid (pl_valid),
    .pl_ready (pl_ready),
    .pl_last  (pl_last),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO model: a pop seen before the edge removes the head; flags refresh just after.
  always @(posedge clk) begin
    cycle_cnt++;
    if (pop_next && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
    pop_next = 1'b0;
    #1;
    rx_empty = (fifo_q.size() == 0);
    rd_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  end

  always @(negedge clk) begin
    pop_next = rd_uart;
    if (rd_uart) pop_edge = cycle_cnt + 1;
    if (pl_valid && pl_ready) begin
      got_data.push_back(pl_data);
      got_last.push_back(pl_last);
      got_cycle.push_back(cycle_cnt);
    end
    if (frame_ok) ok_count++;
    if (frame_err) begin
      err_count++;
      err_cycle = cycle_cnt;
    end
    if (frame_ok && frame_err) both_high++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input int n, input logic [63:0] bytes);
    @(negedge clk);
    for (int i = 0; i < n; i++) fifo_q.push_back(bytes[(n-1-i)*8 +: 8]);
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setReady(input logic value);
    @(posedge clk);
    #1 pl_ready = value;
  endtask

  task automatic clearRecords();
    @(posedge clk);
    #3;
    got_data.delete();
    got_last.delete();
    got_cycle.delete();
    ok_count  = 0;
    err_count = 0;
  endtask

  task automatic checkPayload(input string tag, input int n, input logic [31:0] exp_bytes,
                              input logic [3:0] exp_last);
    checkOutput({tag, "_count"}, got_data.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_data.size()) begin
        checkOutput({tag, "_data"}, {24'd0, got_data[i]}, {24'd0, exp_bytes[(n-1-i)*8 +: 8]});
        checkOutput({tag, "_last"}, {31'd0, got_last[i]}, {31'd0, exp_last[n-1-i]});
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_empty = 1'b1;
    rd_data  = 8'h00;
    pl_ready = 1'b1;
    runCycles(3);
    checkOutput("reset_outputs", {20'd0, rd_uart, pl_valid, pl_last, frame_ok, frame_err, err_code, pl_data}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    runCycles(2);

    // Plain frame at full throughput
    clearRecords();
    applyStimulus(6, 64'h0000_A503_1122_3303);
    runCycles(20);
    checkPayload("t1", 3, 32'h0011_2233, 4'b0001);
    if (got_cycle.size() >= 3) begin
      checkOutput("t1_gap01", got_cycle[1] - got_cycle[0], 1);
      checkOutput("t1_gap12", got_cycle[2] - got_cycle[1], 1);
    end
    checkOutput("t1_ok", ok_count, 1);
    checkOutput("t1_err", err_count, 0);
    checkOutput("t1_code", {30'd0, err_code}, 0);

    // Bad checksum, then an empty frame clears err_code
    clearRecords();
    applyStimulus(5, 64'h0000_00A5_0210_20FF);
    runCycles(20);
    checkPayload("t2a", 2, 32'h0000_1020, 4'b0001);
    checkOutput("t2a_ok", ok_count, 0);
    checkOutput("t2a_err", err_count, 1);
    checkOutput("t2a_code", {30'd0, err_code}, 2);
    clearRecords();
    applyStimulus(3, 64'h0000_0000_00A5_0000);
    runCycles(15);
    checkOutput("t2b_count", got_data.size(), 0);
    checkOutput("t2b_ok", ok_count, 1);
    checkOutput("t2b_err", err_count, 0);
    checkOutput("t2b_code", {30'd0, err_code}, 0);

    // Junk before SOF, then LEN above the limit
    clearRecords();
    applyStimulus(4, 64'h0000_0000_007E_A520);
    runCycles(15);
    checkOutput("t3_count", got_data.size(), 0);
    checkOutput("t3_ok", ok_count, 0);
    checkOutput("t3_err", err_count, 1);
    checkOutput("t3_code", {30'd0, err_code}, 1);

    // Downstream stall longer than the timeout must hold data and not time out
    setReady(1'b0);
    clearRecords();
    applyStimulus(6, 64'h0000_A503_1122_3303);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = pl_valid;
    end
    checkOutput("t4_first_valid", {31'd0, seen}, 1);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (pl_data !== 8'h11 || pl_valid !== 1'b1 || rd_uart !== 1'b0) bad++;
    end
    checkOutput("t4_stall_hold", bad, 0);
    checkOutput("t4_err_in_stall", err_count, 0);
    setReady(1'b1);
    runCycles(20);
    checkPayload("t4", 3, 32'h0011_2233, 4'b0001);
    checkOutput("t4_ok", ok_count, 1);
    checkOutput("t4_err", err_count, 0);
    checkOutput("t4_code", {30'd0, err_code}, 0);

    // Inter-byte timeout 50 cycles after the last pop
    clearRecords();
    applyStimulus(3, 64'h0000_0000_00A5_0401);
    runCycles(70);
    checkPayload("t5", 1, 32'h0000_0001, 4'b0000);
    checkOutput("t5_err", err_count, 1);
    checkOutput("t5_ok", ok_count, 0);
    checkOutput("t5_code", {30'd0, err_code}, 3);
    checkOutput("t5_latency", err_cycle - pop_edge, 50);
    clearRecords();
    applyStimulus(3, 64'h0000_0000_00A5_0000);
    runCycles(15);
    checkOutput("t5b_ok", ok_count, 1);
    checkOutput("t5b_code", {30'd0, err_code}, 0);

    // Reset in the middle of a payload
    clearRecords();
    applyStimulus(4, 64'h0000_0000_A501_0700);
    runCycles(15);
    checkOutput("t6_pre_err", err_count, 1);
    checkOutput("t6_pre_code", {30'd0, err_code}, 2);
    clearRecords();
    applyStimulus(8, 64'hA505_0102_0304_0504);
    for (int i = 0; i < 30 && got_data.size() < 2; i++) @(negedge clk);
    checkOutput("t6_mid_payload", {31'd0, (got_data.size() >= 2)}, 1);
    #2 rst = 1'b1;
    fifo_q.delete();
    #1;
    checkOutput("t6_reset_outputs", {20'd0, rd_uart, pl_valid, pl_last, frame_ok, frame_err, err_code, pl_data}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    clearRecords();
    runCycles(10);
    checkOutput("t6_no_pulse", ok_count + err_count, 0);
    applyStimulus(5, 64'h0000_00A5_02AA_55FD);
    runCycles(15);
    checkPayload("t6", 2, 32'h0000_AA55, 4'b0001);
    checkOutput("t6_ok", ok_count, 1);
    checkOutput("t6_err", err_count, 0);
    checkOutput("t6_code", {30'd0, err_code}, 0);

    checkOutput("never_both", both_high, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
